// File: rtl/pstprc_ram_wr_ctrl_pkg.sv
// Shared definitions for the post-process sample RAM writer: FSM state
// encodings and the fixed widths seen by Dmod_Seg.
package pstprc_ram_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WRITE       = 2'd1,
    ST_WAIT_PSTPRC = 2'd2
  } wr_state_e;

  localparam int SMPL_PER_WORD_LOG2 = 2;
  localparam int PSTPRC_ADDR_W      = 11;
  localparam int DEPTH_W            = 16;
  localparam int MISS_W             = 8;

endpackage

// File: rtl/pstprc_trig_edge.sv
// Rising-edge detector for the raw sample trigger level; the delayed copy
// clears on reset so a level already high afterwards reads as an edge.
module pstprc_trig_edge
  import pstprc_ram_wr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic trig_edge
);

  logic trig_d;

  always_ff @(posedge clk) begin
    if (!rst_n) trig_d <= 1'b0;
    else        trig_d <= trig;
  end

  assign trig_edge = trig & ~trig_d;

endmodule

// File: rtl/pstprc_ram_wr_ctrl.sv
// Writer for the post-process I/Q sample RAMs: captures one burst per accepted
// trigger edge and holds off new captures until Dmod_Seg signals completion.
module pstprc_ram_wr_ctrl
  import pstprc_ram_wr_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = PSTPRC_ADDR_W,
  parameter int SMPL_PER_WORD = 1 << SMPL_PER_WORD_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_trig,
  input  logic [DEPTH_W-1:0]  cmd_smpl_depth,
  input  logic                adc_valid,
  input  logic [DATA_W-1:0]   adc_dataI,
  input  logic [DATA_W-1:0]   adc_dataQ,
  input  logic                Pstprc_finish,
  output logic                posedge_sample_trig,
  output logic                Pstprc_RAMI_wea,
  output logic                Pstprc_RAMQ_wea,
  output logic [ADDR_W-1:0]   Pstprc_RAM_addra,
  output logic [DATA_W-1:0]   Pstprc_RAMI_dina,
  output logic [DATA_W-1:0]   Pstprc_RAMQ_dina,
  output logic                wr_busy,
  output logic                wr_done,
  output logic [MISS_W-1:0]   trig_miss_cnt
);

  localparam int SPW_LOG2 = $clog2(SMPL_PER_WORD);
  localparam int SUM_W    = DEPTH_W + 1;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Round samples up to whole RAM words, clamped so the address never wraps.
  function automatic logic [ADDR_W:0] words_calc(input logic [DEPTH_W-1:0] depth);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, depth} + SUM_W'(SMPL_PER_WORD - 1);
    sum = sum >> SPW_LOG2;
    if (sum > SUM_W'(WORDS_MAX)) words_calc = WORDS_MAX;
    else                         words_calc = sum[ADDR_W:0];
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    if (v == {MISS_W{1'b1}}) sat_inc = v;
    else                     sat_inc = v + 1'b1;
  endfunction

  wr_state_e          state;
  logic [ADDR_W-1:0]  cnt;
  logic [ADDR_W:0]    words_lat;
  logic [ADDR_W:0]    words_now;
  logic               trig_edge;
  logic               accept;

  logic               posedge_p1;
  logic               vld_p1;
  logic               last_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  dina_i_p1;
  logic [DATA_W-1:0]  dina_q_p1;
  logic               wr_done_p2;
  logic [MISS_W-1:0]  miss_cnt;

  pstprc_trig_edge u_trig_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (sample_trig),
    .trig_edge (trig_edge)
  );

  assign words_now = words_calc(cmd_smpl_depth);
  // A finish arriving with an edge frees the RAMs in time for the new capture.
  assign accept    = trig_edge &
                     ((state == ST_IDLE) || ((state == ST_WAIT_PSTPRC) && Pstprc_finish));

  // Stage p1: FSM, address counter and registered RAM write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      words_lat   <= '0;
      posedge_p1  <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      addr_p1     <= '0;
      dina_i_p1   <= '0;
      dina_q_p1   <= '0;
      wr_done_p2  <= 1'b0;
      miss_cnt    <= '0;
    end else begin
      posedge_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      wr_done_p2 <= last_p1;

      if (trig_edge && !accept) miss_cnt <= sat_inc(miss_cnt);

      if (accept) begin
        posedge_p1 <= 1'b1;
        words_lat  <= words_now;
        cnt        <= '0;
        if (words_now == '0) begin
          wr_done_p2 <= 1'b1;
          state      <= ST_IDLE;
        end else begin
          state      <= ST_WRITE;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_WRITE: begin
            if (adc_valid) begin
              vld_p1    <= 1'b1;
              addr_p1   <= cnt;
              dina_i_p1 <= adc_dataI;
              dina_q_p1 <= adc_dataQ;
              cnt       <= cnt + 1'b1;
              if ({1'b0, cnt} == words_lat - 1'b1) begin
                last_p1 <= 1'b1;
                state   <= ST_WAIT_PSTPRC;
              end
            end
          end
          ST_WAIT_PSTPRC: begin
            if (Pstprc_finish) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign posedge_sample_trig = posedge_p1;
  assign Pstprc_RAMI_wea     = vld_p1;
  assign Pstprc_RAMQ_wea     = vld_p1;
  assign Pstprc_RAM_addra    = addr_p1;
  assign Pstprc_RAMI_dina    = dina_i_p1;
  assign Pstprc_RAMQ_dina    = dina_q_p1;
  assign wr_busy             = (state != ST_IDLE);
  assign wr_done             = wr_done_p2;
  assign trig_miss_cnt       = miss_cnt;

endmodule

// File: tb/tb_pstprc_ram_wr_ctrl.sv
// Directed bench for pstprc_ram_wr_ctrl: per-cycle vector table plus long
// capture sequences for full-depth and clamped-depth bursts.
module tb_pstprc_ram_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_trig;
  logic [15:0] cmd_smpl_depth;
  logic        adc_valid;
  logic [31:0] adc_dataI;
  logic [31:0] adc_dataQ;
  logic        Pstprc_finish;
  logic        posedge_sample_trig;
  logic        Pstprc_RAMI_wea;
  logic        Pstprc_RAMQ_wea;
  logic [10:0] Pstprc_RAM_addra;
  logic [31:0] Pstprc_RAMI_dina;
  logic [31:0] Pstprc_RAMQ_dina;
  logic        wr_busy;
  logic        wr_done;
  logic [7:0]  trig_miss_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pstprc_ram_wr_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sample_trig         (sample_trig),
    .cmd_smpl_depth      (cmd_smpl_depth),
    .adc_valid           (adc_valid),
    .adc_dataI           (adc_dataI),
    .adc_dataQ           (adc_dataQ),
    .Pstprc_finish       (Pstprc_finish),
    .posedge_sample_trig (posedge_sample_trig),
    .Pstprc_RAMI_wea     (Pstprc_RAMI_wea),
    .Pstprc_RAMQ_wea     (Pstprc_RAMQ_wea),
    .Pstprc_RAM_addra    (Pstprc_RAM_addra),
    .Pstprc_RAMI_dina    (Pstprc_RAMI_dina),
    .Pstprc_RAMQ_dina    (Pstprc_RAMQ_dina),
    .wr_busy             (wr_busy),
    .wr_done             (wr_done),
    .trig_miss_cnt       (trig_miss_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        trig;
    logic        valid;
    logic        fin;
    logic [15:0] depth;
    logic [31:0] di;
    logic        pst;
    logic        wea;
    logic [10:0] addr;
    logic        done;
    logic        busy;
    logic [7:0]  miss;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
  endtask

  task automatic add(input logic r, input logic t, input logic v, input logic f,
                     input logic [15:0] d, input logic [31:0] di, input logic pst,
                     input logic wea, input logic [10:0] a, input logic done,
                     input logic busy, input logic [7:0] miss);
    vec_t x;
    x.rst_n = r; x.trig = t; x.valid = v; x.fin = f; x.depth = d; x.di = di;
    x.pst = pst; x.wea = wea; x.addr = a; x.done = done; x.busy = busy; x.miss = miss;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic t, input logic v, input logic f,
                       input logic [15:0] d, input logic [31:0] di);
    rst_n = r; sample_trig = t; adc_valid = v; Pstprc_finish = f;
    cmd_smpl_depth = d; adc_dataI = di; adc_dataQ = ~di;
  endtask

  // One capture with adc_valid held high; returns after finish is acknowledged.
  task automatic run_capture(input string tag, input logic [15:0] depth,
                             input int exp_words);
    int n, mism, first_cyc, last_cyc, done_cyc;
    logic [10:0] last_addr;
    n = 0; mism = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; last_addr = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, depth, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, depth, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, depth, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_pst"}, 0, 32'(posedge_sample_trig), 32'd1);
    chk({tag, "_busy_start"}, 0, 32'(wr_busy), 32'd1);
    for (int cyc = 0; cyc < exp_words + 16; cyc++) begin
      adc_dataI = 32'(cyc); adc_dataQ = ~32'(cyc);
      @(posedge clk); #1;
      if (Pstprc_RAMI_wea) begin
        if (Pstprc_RAM_addra != 11'(n)) mism++;
        if (Pstprc_RAMQ_wea !== 1'b1) mism++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc; last_addr = Pstprc_RAM_addra; n++;
      end
      if (wr_done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, "_writes"}, 0, 32'(n), 32'(exp_words));
    chk({tag, "_addr_seq"}, 0, 32'(mism), 32'd0);
    chk({tag, "_consecutive"}, 0, 32'(last_cyc - first_cyc + 1), 32'(exp_words));
    chk({tag, "_last_addr"}, 0, 32'(last_addr), 32'(exp_words - 1));
    chk({tag, "_done_gap"}, 0, 32'(done_cyc - last_cyc), 32'd1);
    adc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_busy_wait"}, 0, 32'(wr_busy), 32'd1);
    Pstprc_finish = 1'b1;
    @(posedge clk); #1;
    Pstprc_finish = 1'b0;
    chk({tag, "_busy_end"}, 0, 32'(wr_busy), 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0);

    //  rst trig vld fin depth   data          pst wea addr done busy miss
    add(0, 0, 0, 0, 16'd5,   32'h0,        0, 0, 11'd0, 0, 0, 8'd0);
    add(1, 0, 0, 0, 16'd5,   32'h0,        0, 0, 11'd0, 0, 0, 8'd0);
    add(1, 1, 0, 0, 16'd5,   32'h0,        1, 0, 11'd0, 0, 1, 8'd0);
    add(1, 1, 1, 0, 16'd5,   32'hA1A1_0001, 0, 1, 11'd0, 0, 1, 8'd0);
    add(1, 0, 0, 0, 16'd5,   32'hB0B0_0000, 0, 0, 11'd0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 16'd5,   32'hB0B0_0001, 0, 0, 11'd0, 0, 1, 8'd1);
    add(1, 1, 1, 0, 16'd5,   32'hA2A2_0002, 0, 1, 11'd1, 0, 1, 8'd1);
    add(1, 0, 1, 0, 16'd5,   32'hA3A3_0003, 0, 0, 11'd0, 1, 1, 8'd1);
    add(1, 1, 1, 0, 16'd5,   32'hA3A3_0004, 0, 0, 11'd0, 0, 1, 8'd2);
    add(1, 0, 0, 0, 16'd5,   32'h0,        0, 0, 11'd0, 0, 1, 8'd2);
    add(1, 1, 0, 1, 16'd12,  32'h0,        1, 0, 11'd0, 0, 1, 8'd2);
    add(1, 1, 1, 1, 16'd12,  32'hA4A4_0004, 0, 1, 11'd0, 0, 1, 8'd2);
    add(1, 0, 1, 0, 16'h100, 32'hA5A5_0005, 0, 1, 11'd1, 0, 1, 8'd2);
    add(1, 0, 1, 0, 16'h100, 32'hA6A6_0006, 0, 1, 11'd2, 0, 1, 8'd2);
    add(1, 0, 0, 0, 16'h100, 32'h0,        0, 0, 11'd0, 1, 1, 8'd2);
    add(1, 0, 0, 1, 16'h100, 32'h0,        0, 0, 11'd0, 0, 0, 8'd2);
    add(1, 0, 1, 1, 16'h100, 32'h0,        0, 0, 11'd0, 0, 0, 8'd2);
    add(1, 1, 1, 0, 16'd0,   32'h0,        1, 0, 11'd0, 1, 0, 8'd2);
    add(1, 0, 1, 0, 16'd0,   32'h0,        0, 0, 11'd0, 0, 0, 8'd2);
    add(1, 1, 0, 0, 16'd5,   32'h0,        1, 0, 11'd0, 0, 1, 8'd2);
    add(1, 0, 1, 0, 16'd5,   32'hA7A7_0007, 0, 1, 11'd0, 0, 1, 8'd2);
    add(0, 0, 1, 0, 16'd5,   32'hA7A7_0008, 0, 0, 11'd0, 0, 0, 8'd0);
    add(1, 1, 0, 0, 16'd5,   32'h0,        1, 0, 11'd0, 0, 1, 8'd0);
    add(1, 0, 1, 0, 16'd5,   32'hA8A8_0008, 0, 1, 11'd0, 0, 1, 8'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].trig, vecs[i].valid, vecs[i].fin,
            vecs[i].depth, vecs[i].di);
      @(posedge clk); #1;
      chk("pst",   i, 32'(posedge_sample_trig), 32'(vecs[i].pst));
      chk("weaI",  i, 32'(Pstprc_RAMI_wea),     32'(vecs[i].wea));
      chk("weaQ",  i, 32'(Pstprc_RAMQ_wea),     32'(vecs[i].wea));
      chk("done",  i, 32'(wr_done),             32'(vecs[i].done));
      chk("busy",  i, 32'(wr_busy),             32'(vecs[i].busy));
      chk("miss",  i, 32'(trig_miss_cnt),       32'(vecs[i].miss));
      if (vecs[i].wea) begin
        chk("addr",  i, 32'(Pstprc_RAM_addra), 32'(vecs[i].addr));
        chk("dinaI", i, Pstprc_RAMI_dina,      vecs[i].di);
        chk("dinaQ", i, Pstprc_RAMQ_dina,      ~vecs[i].di);
      end
    end

    run_capture("d2000", 16'h07d0, 500);
    run_capture("dmax",  16'hFFFF, 2048);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
